dm_store_buffer: RTL

- Word-store write buffer placed directly upstream of the data memory in the single-cycle MIPS datapath.
- Queues sw stores from the core in a DEPTH-entry FIFO and drains them to the data memory one per idle cycle.
- Arbitrates the data memory's single shared address port between loads and drains; loads take priority.
- Forwards the youngest buffered matching word to loads so memory appears coherent to the core.

---
 rtl/dm_store_buffer_if.sv | 38 +++
 rtl/dm_store_buffer.sv | 90 +++++++++
 2 files changed

// File: rtl/dm_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : dm_store_buffer_if
// Purpose : Core/memory-side bus bundle for the data-memory store buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface dm_store_buffer_if #(
    parameter int PTR_W = 2
);
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [31:0]      st_pc;
    logic             st_ready;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic [31:0]      ld_data;
    logic [31:0]      dm_a;
    logic             dm_we;
    logic [31:0]      dm_wd;
    logic [31:0]      dm_pc;
    logic [31:0]      dm_rd;
    logic             empty;
    logic [PTR_W:0]   count;

    // Core/memory side: drives requests and memory read data.
    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_rd,
        input  st_ready, ld_data, dm_a, dm_we, dm_wd, dm_pc, empty, count
    );

    // Store buffer side.
    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_rd,
        output st_ready, ld_data, dm_a, dm_we, dm_wd, dm_pc, empty, count
    );
endinterface
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module  : dm_store_buffer
// Purpose : FIFO word-store buffer in front of data memory with load priority
//           and youngest-match load forwarding.
// Revision: 1.0 - initial release
// ============================================================================
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    dm_store_buffer_if.slave  bus
);
    localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drain;
    logic             w_hit;
    logic [31:0]      w_fwd;
    logic [PTR_W-1:0] w_idx;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.st_valid && !w_full && !reset;
    assign w_drain = !w_empty && !bus.ld_valid && !reset;

    // Payload needs no reset: validity is derived from head/count only.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.st_addr[31:2];
            r_data[r_tail] <= bus.st_data;
            r_pc[r_tail]   <= bus.st_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (((PTR_W+1)'(k) < r_count) && (r_addr[w_idx] == bus.ld_addr[31:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    assign bus.st_ready = !w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.dm_we    = w_drain;
    assign bus.dm_a     = bus.ld_valid ? bus.ld_addr : {r_addr[r_head], 2'b00};
    assign bus.dm_wd    = r_data[r_head];
    assign bus.dm_pc    = r_pc[r_head];
    assign bus.ld_data  = w_hit ? w_fwd : bus.dm_rd;
endmodule
`default_nettype wire
